// File: rtl/mac_fetch_mult.sv
// Operand fetch + multiply stage: walks (i,j,k) over C = A*B, reads both SRAMs,
// and emits registered products with cycle-aligned index tags. Optional issue stall via MAC_FETCH_STALL_EN.
module mac_fetch_mult #(
    parameter int M                      = 4,
    parameter int K                      = 4,
    parameter int N                      = 4,
    parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  start,
`ifdef MAC_FETCH_STALL_EN
    input  logic                                  stall,
`endif
    output logic                                  busy,
    output logic                                  done,
    output logic                                  matrix_a_re,
    output logic                                  matrix_b_re,
    output logic [$clog2(M)-1:0]                  matrix_a_row_addr,
    output logic [$clog2(K)-1:0]                  matrix_a_col_addr,
    output logic [$clog2(K)-1:0]                  matrix_b_row_addr,
    output logic [$clog2(N)-1:0]                  matrix_b_col_addr,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     matrix_a_rdata,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     matrix_b_rdata,
    output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
    output logic [$clog2(M)-1:0]                  matrix_a_row_addr_counter_reg,
    output logic [$clog2(K)-1:0]                  matrix_a_col_addr_counter_reg,
    output logic [$clog2(K)-1:0]                  matrix_b_row_addr_counter_reg,
    output logic [$clog2(N)-1:0]                  matrix_b_col_addr_counter_reg,
    output logic                                  mult_done_reg
);

    localparam int W      = DATA_WIDTH_INIT_MATRIX;
    localparam int IW     = $clog2(M);
    localparam int KW     = $clog2(K);
    localparam int JW     = $clog2(N);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [IW-1:0] i;
        logic [JW-1:0] j;
        logic [KW-1:0] k;
    } tag_t;

    state_t state_q, state_d;
    logic   stall_i;

`ifdef MAC_FETCH_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [KW-1:0] k_q;
    logic          issue, i_last, j_last, k_last, last_issue;

    assign issue      = (state_q == ISSUE) && !stall_i;
    assign i_last     = (i_q == IW'(M - 1));
    assign j_last     = (j_q == JW'(N - 1));
    assign k_last     = (k_q == KW'(K - 1));
    assign last_issue = issue && i_last && j_last && k_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (done)       state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // k innermost, then j, then i; the final carry returns all three to 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (state_q == IDLE) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (issue) begin
            k_q <= k_last ? '0 : k_q + KW'(1);
            if (k_last) begin
                j_q <= j_last ? '0 : j_q + JW'(1);
                if (j_last) i_q <= i_last ? '0 : i_q + IW'(1);
            end
        end
    end

    assign busy              = (state_q != IDLE);
    assign matrix_a_re       = issue;
    assign matrix_b_re       = issue;
    assign matrix_a_row_addr = i_q;
    assign matrix_a_col_addr = k_q;
    assign matrix_b_row_addr = k_q;
    assign matrix_b_col_addr = j_q;

    // [0]: read in flight at SRAM, [1]: operands registered, [2]: product presented
    logic [STAGES:0] vld_pipe, last_pipe;
    tag_t            tag0, tag1, tag2;
    logic [W-1:0]    a_q, b_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe    <= '0;
            last_pipe   <= '0;
            tag0        <= '0;
            tag1        <= '0;
            tag2        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            product_reg <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
            last_pipe <= {last_pipe[STAGES-1:0], last_issue};
            tag0      <= '{i: i_q, j: j_q, k: k_q};
            tag1      <= tag0;
            a_q       <= matrix_a_rdata;
            b_q       <= matrix_b_rdata;
            // bubbles are zeroed so downstream never sees a stale k==K-1
            if (vld_pipe[1]) begin
                product_reg <= {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
                tag2        <= tag1;
            end else begin
                product_reg <= '0;
                tag2        <= '0;
            end
        end
    end

    assign mult_done_reg                 = vld_pipe[STAGES];
    assign done                          = last_pipe[STAGES];
    assign matrix_a_row_addr_counter_reg = tag2.i;
    assign matrix_a_col_addr_counter_reg = tag2.k;
    assign matrix_b_row_addr_counter_reg = tag2.k;
    assign matrix_b_col_addr_counter_reg = tag2.j;

endmodule

// File: tb/tb_mac_fetch_mult.sv
// Scoreboard bench for mac_fetch_mult: a driver pushes expected products computed
// from the matrices, a negedge monitor pops and compares whatever the DUT presents.
module tb_mac_fetch_mult;
    localparam int M = 4, K = 4, N = 4, W = 8;
    localparam int MNK = M * K * N;
    localparam int IW = $clog2(M), KW = $clog2(K), JW = $clog2(N);

    logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
`ifdef MAC_FETCH_STALL_EN
    logic stall = 1'b0;
`endif
    logic busy, done, a_re, b_re, mult_done;
    logic [IW-1:0] a_row, tag_i;
    logic [KW-1:0] a_col, b_row, tag_ka, tag_kb;
    logic [JW-1:0] b_col, tag_j;
    logic [W-1:0] a_rdata, b_rdata;
    logic [2*W-1:0] product;

    mac_fetch_mult #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(W)) dut (
        .clk(clk), .resetn(resetn), .start(start),
`ifdef MAC_FETCH_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done),
        .matrix_a_re(a_re), .matrix_b_re(b_re),
        .matrix_a_row_addr(a_row), .matrix_a_col_addr(a_col),
        .matrix_b_row_addr(b_row), .matrix_b_col_addr(b_col),
        .matrix_a_rdata(a_rdata), .matrix_b_rdata(b_rdata),
        .product_reg(product),
        .matrix_a_row_addr_counter_reg(tag_i),
        .matrix_a_col_addr_counter_reg(tag_ka),
        .matrix_b_row_addr_counter_reg(tag_kb),
        .matrix_b_col_addr_counter_reg(tag_j),
        .mult_done_reg(mult_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data returned the cycle after re is sampled; garbage otherwise
    logic [W-1:0] A [M][K];
    logic [W-1:0] B [K][N];
    always @(posedge clk) begin
        a_rdata <= a_re ? A[a_row][a_col] : W'($urandom);
        b_rdata <= b_re ? B[b_row][b_col] : W'($urandom);
    end

    typedef struct {
        longint p;
        int     i, j, k;
        bit     last;
        int     at;
    } exp_t;
    exp_t q[$];

    int tests = 0, fails = 0;
    int t;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (mult_done) begin
                    if (q.size() == 0) chk("extra_product", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("product", product, e.p);
                        chk("tag_i", tag_i, e.i);
                        chk("tag_j", tag_j, e.j);
                        chk("tag_k_a", tag_ka, e.k);
                        chk("tag_k_b", tag_kb, e.k);
                        chk("done_flag", done, e.last);
                        if (e.at >= 0) chk("product_cycle", cyc, e.at);
                    end
                end else begin
                    chk("bubble_clear",
                        (product != 0 || tag_i != 0 || tag_ka != 0 || tag_kb != 0 ||
                         tag_j != 0 || done) ? 1 : 0, 0);
                end
            end
        end
    end

    task automatic fill(input bit maxval);
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) A[i][k] = maxval ? '1 : W'($urandom);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) B[k][j] = maxval ? '1 : W'($urandom);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_re"}, {a_re, b_re}, 0);
        chk({name, "_addr"}, {a_row, a_col, b_row, b_col}, 0);
        chk({name, "_outs"}, {mult_done, done, product != 0}, 0);
    endtask

    // mode 0 plain, 1 stall after slot 2, 2 start re-pulsed while busy, 3 reset at slot 5
    task automatic run_pass(input int mode);
        int s, stall_len;
        bit seen;
        stall_len = (mode == 1) ? 3 : 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; t = cyc;
        chk("busy_after_start", busy, 1);
        chk("re_after_start", {a_re, b_re}, 2'b11);
        s = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < K; k++) begin
                    exp_t e;
                    e.p = longint'(A[i][k]) * longint'(B[k][j]);
                    e.i = i; e.j = j; e.k = k;
                    e.last = (s == MNK - 1);
                    e.at = t + s + 3 + ((s >= 3) ? stall_len : 0);
                    q.push_back(e);
                    s++;
                end
`ifdef MAC_FETCH_STALL_EN
        if (mode == 1) begin
            repeat (3) @(posedge clk); #1; stall = 1'b1;
            repeat (3) @(posedge clk); #1; stall = 1'b0;
        end
`endif
        if (mode == 2) begin
            repeat (10) @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        if (mode == 3) begin
            repeat (5) @(posedge clk); #1; resetn = 1'b0; #1;
            q.delete();
            check_idle("reset_mid_pass");
            repeat (2) @(posedge clk);
            @(negedge clk); resetn = 1'b1;
            repeat (3) @(posedge clk); #1;
            check_idle("after_reset");
            return;
        end
        seen = 0;
        for (int c = 0; c < MNK + 40 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
        if (seen) chk("done_cycle", cyc, t + MNK + 2 + stall_len);
        if (mode == 2) start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check_idle("post_pass");
        chk("queue_empty", q.size(), 0);
        if (mode == 2) begin
            repeat (10) @(posedge clk); #1;
            check_idle("no_restart");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        fill(0);
        #1;
        check_idle("reset");
        repeat (2) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_idle("idle");
        run_pass(0);
        fill(0); run_pass(0);
        fill(1); run_pass(0);
        fill(0); run_pass(2);
        fill(0); run_pass(3);
        fill(0); run_pass(0);
`ifdef MAC_FETCH_STALL_EN
        fill(0); run_pass(1);
`endif
        repeat (5) @(posedge clk); #1;
        check_idle("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mac_fetch_mult.md
# mac_fetch_mult

Operand-fetch and multiply stage that sits directly upstream of the MAC accumulate/stop stage. On `start` it walks the full index space of C = A·B (i over M rows of A, j over N columns of B, k over K inner elements, k innermost) and issues one read per cycle to SRAM A and SRAM B. It registers the returned operands, multiplies them, and presents `product_reg`, the four index tags and `mult_done_reg` to the accumulate stage with all fields cycle-aligned. It also reports `busy` and pulses `done` when the last product leaves.

## Interface
- `M`, 4, rows of A / C (≥2)
- `K`, 4, inner dimension (≥2)
- `N`, 4, columns of B / C (≥2)
- `DATA_WIDTH_INIT_MATRIX`, 32, operand width (unsigned)
- `clk`  in  1  clock; single clock domain
- `resetn`  in  1  reset; asynchronous, active-low
- `start`  in  1  begin a full matrix pass; ignored while `busy`
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse coincident with the last `mult_done_reg`
- `matrix_a_re`, `matrix_b_re`  out  1  SRAM read enables
- `matrix_a_row_addr`  out  $clog2(M)  = issue i
- `matrix_a_col_addr`, `matrix_b_row_addr`  out  $clog2(K)  = issue k
- `matrix_b_col_addr`  out  $clog2(N)  = issue j
- `matrix_a_rdata`, `matrix_b_rdata`  in  DATA_WIDTH_INIT_MATRIX  SRAM data; valid the cycle after the edge that sampled `re`
- `product_reg`  out  2·DATA_WIDTH_INIT_MATRIX  registered A·B
- `matrix_a_row_addr_counter_reg`  out  $clog2(M)  i tag of `product_reg`
- `matrix_a_col_addr_counter_reg`, `matrix_b_row_addr_counter_reg`  out  $clog2(K)  k tag
- `matrix_b_col_addr_counter_reg`  out  $clog2(N)  j tag
- `mult_done_reg`  out  1  `product_reg` and tags valid
- `stall`  in  1  present only with `MAC_FETCH_STALL_EN`

## Operation
- FSM states:
  - IDLE → ISSUE on `start`.
  - ISSUE → DRAIN at the edge that issues (M-1,N-1,K-1).
  - DRAIN → IDLE at the edge after `done`.
- Issue counters i, j, k:
  - reset and held at 0 in IDLE;
  - advance on every issuing edge: k wraps K-1→0 and carries to j; j wraps N-1→0 and carries to i.
- Both `re` signals = (state==ISSUE) & ~stall. SRAM addresses always equal the issue counters.
- Pipeline:
  - Stage 1 captures both rdata words plus tags and a valid bit one cycle after the read.
  - Stage 2 computes `product_reg` = a·b (full 2W width, unsigned, no truncation), copies the tags and sets `mult_done_reg` = valid.
- Bubble slots (valid=0) force `product_reg` = 0 and all four tag outputs = 0, so the downstream stage never sees a spurious k==K-1.
- `busy` = state≠IDLE.
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-pass: in-flight data is discarded and there is no `done`.
- `start` while `busy`, including during the `done` cycle: ignored.
- `start` and reset deassertion in the same cycle: `start` is ignored until the first edge with `resetn` high.

## Timing
- `start` sampled at edge t. Slot s (0…MNK-1) is issued in the cycle after edge t+s, enters stage 1 at edge t+s+2, and appears on the outputs after edge t+s+3.
  - Latency from issue to `mult_done_reg` is 3 edges.
- No stall: `mult_done_reg` is high continuously from after edge t+3 through the cycle after edge t+MNK+2.
  - `done` is high in that final cycle.
  - `busy` falls at edge t+MNK+3.
- Throughput: one product per cycle.

## Configuration
- `MAC_FETCH_STALL_EN` defined:
  - The `stall` port exists.
  - `stall` high in a cycle deasserts `re` and holds the issue counters.
  - Already-issued slots keep draining and produce bubbles downstream.
  - `stall` in IDLE or DRAIN has no effect.
- Not defined: no `stall` port; issue never pauses.

## Test plan
- **Basic products.** M=K=N=2, W=8, A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse `start` -> `product_reg` sequence 5,14,6,16,15,28,18,32 on consecutive cycles from edge t+3, with tags (i,j,k) counting 000…111, and `done` on the 8th product.
- **Max-value operands.** All operands 0xFF, W=8 -> every product 0xFE01 with no truncation; tag wrap is correct at default M=K=N=4 (64 products, `done` after edge t+66).
- **Stall (macro on).** `stall` held for 3 cycles after slot 2 is issued -> 3 bubbles with `mult_done_reg`=0 and tags 0, products unchanged, `done` 3 cycles later.
- **Start while busy.** `start` re-pulsed mid-pass and again in the `done` cycle -> ignored; exactly one pass of MNK products.
- **Reset mid-pass.** `resetn` low at slot 5 -> all outputs 0 immediately, no `done`; a following `start` gives a clean pass from (0,0,0).
- **Idle after a pass.** After `done` -> all outputs 0, `busy`=0, both `re`=0, addresses 0.
